// File: rtl/i2c_pkg.sv
// i2c_pkg: shared types and constants for the I2C initiator.
// FSM states, R/W bit codes, default responder address, quarter phases.
package i2c_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_TXBYTE,
    ST_TXACK,
    ST_RSTART,
    ST_RXBYTE,
    ST_RXNACK,
    ST_STOP
  } i2c_state_e;

  localparam logic I2C_RW_WRITE = 1'b0;
  localparam logic I2C_RW_READ  = 1'b1;

  localparam logic [6:0] I2C_DEF_DEV = 7'h70;

  localparam logic [1:0] Q0 = 2'd0;
  localparam logic [1:0] Q1 = 2'd1;
  localparam logic [1:0] Q2 = 2'd2;
  localparam logic [1:0] Q3 = 2'd3;

  function automatic logic [7:0] i2c_addr_byte(
    input logic [6:0] dev,
    input logic       rw
  );
    return {dev, rw};
  endfunction

endpackage

// File: rtl/i2c_master_if.sv
// i2c_master_if: command handshake, status and open-drain pin bundle.
// master = controller view, slave = host/pin-side view.
interface i2c_master_if;
  import i2c_pkg::*;

  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_rw;
  logic [6:0] cmd_dev;
  logic [7:0] cmd_reg;
  logic [7:0] cmd_wdata;
  logic       busy;
  logic       done;
  logic       ack_err;
  logic [7:0] rdata;
  logic       scl_o;
  logic       scl_oe;
  logic       scl_i;
  logic       sda_o;
  logic       sda_oe;
  logic       sda_i;

  modport master (
    input  cmd_valid, cmd_rw, cmd_dev,
    input  cmd_reg, cmd_wdata,
    input  scl_i, sda_i,
    output cmd_ready, busy, done,
    output ack_err, rdata,
    output scl_o, scl_oe, sda_o, sda_oe
  );

  modport slave (
    output cmd_valid, cmd_rw, cmd_dev,
    output cmd_reg, cmd_wdata,
    output scl_i, sda_i,
    input  cmd_ready, busy, done,
    input  ack_err, rdata,
    input  scl_o, scl_oe, sda_o, sda_oe
  );

endinterface

// File: rtl/i2c_qtick.sv
// i2c_qtick: quarter-SCL-period timebase, 0..QDIV-1 with wrap tick.
// Ports: clk, rst_n, en (else held at 0), hold (freeze), tick.
module i2c_qtick #(
  parameter int QDIV = 125
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic hold,
  output logic tick
);
  import i2c_pkg::*;

  localparam logic [15:0] LAST = 16'(QDIV - 1);

  logic [15:0] cnt;

  assign tick = en && !hold && (cnt == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (!en) begin
      cnt <= '0;
    end else if (!hold) begin
      cnt <= (cnt == LAST) ? '0 : cnt + 16'd1;
    end
  end

endmodule

// File: rtl/i2c_master.sv
// i2c_master: one register write or read per command over open-drain I2C.
// Ports: clk, rst_n, bus (cmd handshake, status, scl/sda pins).
module i2c_master #(
  parameter int QDIV = 125
) (
  input logic          clk,
  input logic          rst_n,
  i2c_master_if.master bus
);
  import i2c_pkg::*;

  i2c_state_e state;
  logic [1:0] qph;
  logic [2:0] bitcnt;
  logic [1:0] byte_sel;
  logic [7:0] shreg;
  logic       rw_q;
  logic [6:0] dev_q;
  logic [7:0] reg_q;
  logic [7:0] wdata_q;
  logic       nack_q;
  logic       busy_q;
  logic       done_q;
  logic       ack_err_q;
  logic [7:0] rdata_q;
  logic       scl_oe_q;
  logic       sda_oe_q;
  logic       tick;
  logic       hold;

  assign bus.cmd_ready = ~busy_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.ack_err   = ack_err_q;
  assign bus.rdata     = rdata_q;
  assign bus.scl_o     = 1'b0;
  assign bus.sda_o     = 1'b0;
  assign bus.scl_oe    = scl_oe_q;
  assign bus.sda_oe    = sda_oe_q;

  // Responder stretching: SCL released but still low at Q2.
  assign hold = (qph == Q2) && !bus.scl_i &&
                (state inside {ST_TXBYTE, ST_TXACK,
                               ST_RXBYTE, ST_RXNACK});

  i2c_qtick #(
    .QDIV (QDIV)
  ) u_qtick (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (busy_q),
    .hold  (hold),
    .tick  (tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      qph       <= Q0;
      bitcnt    <= 3'd7;
      byte_sel  <= 2'd0;
      shreg     <= '0;
      rw_q      <= I2C_RW_WRITE;
      dev_q     <= '0;
      reg_q     <= '0;
      wdata_q   <= '0;
      nack_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      ack_err_q <= 1'b0;
      rdata_q   <= '0;
      scl_oe_q  <= 1'b0;
      sda_oe_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (!busy_q) begin
        if (bus.cmd_valid) begin
          rw_q      <= bus.cmd_rw;
          dev_q     <= bus.cmd_dev;
          reg_q     <= bus.cmd_reg;
          wdata_q   <= bus.cmd_wdata;
          shreg     <= i2c_addr_byte(bus.cmd_dev,
                                     I2C_RW_WRITE);
          byte_sel  <= 2'd0;
          bitcnt    <= 3'd7;
          qph       <= Q0;
          ack_err_q <= 1'b0;
          busy_q    <= 1'b1;
          state     <= ST_START;
        end
      end else if (tick) begin
        qph <= qph + 2'd1;
        unique case (state)
          ST_START: begin
            unique case (qph)
              Q0: begin
                scl_oe_q <= 1'b0;
                sda_oe_q <= 1'b0;
              end
              Q1: sda_oe_q <= 1'b1;
              Q2: ;
              Q3: begin
                scl_oe_q <= 1'b1;
                state    <= ST_TXBYTE;
              end
            endcase
          end
          ST_TXBYTE: begin
            unique case (qph)
              Q0: sda_oe_q <= ~shreg[7];
              Q1: scl_oe_q <= 1'b0;
              Q2: ;
              Q3: begin
                scl_oe_q <= 1'b1;
                shreg    <= {shreg[6:0], 1'b0};
                bitcnt   <= bitcnt - 3'd1;
                if (bitcnt == 3'd0)
                  state <= ST_TXACK;
              end
            endcase
          end
          ST_TXACK: begin
            unique case (qph)
              Q0: sda_oe_q <= 1'b0;
              Q1: scl_oe_q <= 1'b0;
              Q2: nack_q   <= bus.sda_i;
              Q3: begin
                scl_oe_q <= 1'b1;
                if (nack_q) begin
                  ack_err_q <= 1'b1;
                  state     <= ST_STOP;
                end else begin
                  // byte_sel: 0 dev+W, 1 reg, 2 wdata, 3 dev+R
                  unique case (byte_sel)
                    2'd0: begin
                      shreg    <= reg_q;
                      byte_sel <= 2'd1;
                      state    <= ST_TXBYTE;
                    end
                    2'd1: begin
                      if (rw_q == I2C_RW_READ) begin
                        state <= ST_RSTART;
                      end else begin
                        shreg    <= wdata_q;
                        byte_sel <= 2'd2;
                        state    <= ST_TXBYTE;
                      end
                    end
                    2'd2: state <= ST_STOP;
                    2'd3: state <= ST_RXBYTE;
                  endcase
                end
              end
            endcase
          end
          ST_RSTART: begin
            unique case (qph)
              Q0: sda_oe_q <= 1'b0;
              Q1: scl_oe_q <= 1'b0;
              Q2: sda_oe_q <= 1'b1;
              Q3: begin
                scl_oe_q <= 1'b1;
                shreg    <= i2c_addr_byte(dev_q,
                                          I2C_RW_READ);
                byte_sel <= 2'd3;
                state    <= ST_TXBYTE;
              end
            endcase
          end
          ST_RXBYTE: begin
            unique case (qph)
              Q0: sda_oe_q <= 1'b0;
              Q1: scl_oe_q <= 1'b0;
              Q2: shreg    <= {shreg[6:0], bus.sda_i};
              Q3: begin
                scl_oe_q <= 1'b1;
                bitcnt   <= bitcnt - 3'd1;
                if (bitcnt == 3'd0) begin
                  rdata_q <= shreg;
                  state   <= ST_RXNACK;
                end
              end
            endcase
          end
          ST_RXNACK: begin
            unique case (qph)
              Q0: sda_oe_q <= 1'b0;
              Q1: scl_oe_q <= 1'b0;
              Q2: ;
              Q3: begin
                scl_oe_q <= 1'b1;
                state    <= ST_STOP;
              end
            endcase
          end
          ST_STOP: begin
            unique case (qph)
              Q0: sda_oe_q <= 1'b1;
              Q1: scl_oe_q <= 1'b0;
              Q2: sda_oe_q <= 1'b0;
              Q3: begin
                done_q <= 1'b1;
                busy_q <= 1'b0;
                state  <= ST_IDLE;
              end
            endcase
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_master.sv
// tb_i2c_master: directed bench with a bit-level responder at 0x70.
// Logs bus events (S, bytes, ack bits, P) and compares to hand-built lists.
module tb_i2c_master;
  import i2c_pkg::*;

  localparam int QDIV = 50;
  localparam int TW   = 116 * QDIV;
  localparam int TR   = 156 * QDIV;
  localparam int TN   = 44 * QDIV;

  localparam int EV_S = 'h100;
  localparam int EV_P = 'h200;
  localparam int ACK  = 'h400;
  localparam int NAK  = 'h401;

  logic clk;
  logic rst_n;

  i2c_master_if bus ();

  i2c_master #(
    .QDIV (QDIV)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tot = 0;
  int n_bad = 0;
  int cyc = 0;
  int acc_cyc = 0;
  int done_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (bus.done) done_cnt <= done_cnt + 1;

  // responder model
  logic       sl_scl, sl_sda;
  logic       scl, sda;
  logic       p_scl, p_sda;
  int         bitn;
  int         nb;
  logic       skip_fall;
  logic [7:0] shift;
  int         bytei;
  logic       addressed, want_rd, rd_mode;
  logic [7:0] rd_byte;
  logic       str_en;
  int         hold_cnt;
  int         log_q[$];
  int         exp_q[$];

  assign scl = ~(bus.scl_oe | sl_scl);
  assign sda = ~(bus.sda_oe | sl_sda);
  assign bus.scl_i = scl;
  assign bus.sda_i = sda;
  assign nb = (bitn == 8) ? 0 : bitn + 1;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sl_scl <= 1'b0; sl_sda <= 1'b0;
      p_scl <= 1'b1; p_sda <= 1'b1;
      bitn <= 0; skip_fall <= 1'b0; shift <= '0;
      bytei <= 0; addressed <= 1'b0;
      want_rd <= 1'b0; rd_mode <= 1'b0;
      hold_cnt <= 0;
    end else begin
      p_scl <= scl;
      p_sda <= sda;
      if (hold_cnt > 0) begin
        hold_cnt <= hold_cnt - 1;
        if (hold_cnt == 1) sl_scl <= 1'b0;
      end
      if (p_scl && scl && p_sda && !sda) begin
        log_q.push_back(EV_S);
        bitn <= 0; skip_fall <= 1'b1; bytei <= 0;
        addressed <= 1'b0; want_rd <= 1'b0;
        rd_mode <= 1'b0; sl_sda <= 1'b0;
      end else if (p_scl && scl && !p_sda && sda) begin
        log_q.push_back(EV_P);
        bitn <= 0; skip_fall <= 1'b1; bytei <= 0;
        addressed <= 1'b0; rd_mode <= 1'b0;
        sl_sda <= 1'b0;
      end else if (!p_scl && scl) begin
        shift <= {shift[6:0], sda};
        if (bitn == 7) log_q.push_back(int'({shift[6:0], sda}));
        if (bitn == 8) log_q.push_back(ACK + int'(sda));
      end else if (p_scl && !scl) begin
        if (skip_fall) begin
          skip_fall <= 1'b0;
        end else begin
          bitn <= nb;
          if (nb == 8) begin
            if (rd_mode) begin
              sl_sda <= 1'b0;
            end else if (bytei == 0) begin
              addressed <= (shift[7:1] == I2C_DEF_DEV);
              want_rd   <= shift[0];
              sl_sda    <= (shift[7:1] == I2C_DEF_DEV);
            end else begin
              sl_sda <= addressed;
            end
          end else if (nb == 0) begin
            bytei <= bytei + 1;
            if (!rd_mode && bytei == 0 && addressed && want_rd) begin
              rd_mode <= 1'b1;
              sl_sda  <= ~rd_byte[7];
            end else begin
              rd_mode <= 1'b0;
              sl_sda  <= 1'b0;
            end
          end else begin
            if (rd_mode) sl_sda <= ~rd_byte[3'(7 - nb)];
            if (str_en && bytei == 1 && nb == 3) begin
              sl_scl   <= 1'b1;
              hold_cnt <= 1000;
            end
          end
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic check_log(input string tag);
    chk({tag, "_len"}, log_q.size(), exp_q.size());
    foreach (exp_q[i])
      chk($sformatf("%s_ev%0d", tag, i),
          (i < log_q.size()) ? log_q[i] : 32'hFFF, exp_q[i]);
  endtask

  task automatic wait_done(input string tag, output int lat);
    int n = 0;
    while (!bus.done && n < 40000) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_seen"}, bus.done, 1'b1);
    lat = cyc - acc_cyc;
  endtask

  task automatic issue(input logic rw, input logic [6:0] dev,
                       input logic [7:0] rg, input logic [7:0] wd);
    @(negedge clk);
    bus.cmd_rw    = rw;
    bus.cmd_dev   = dev;
    bus.cmd_reg   = rg;
    bus.cmd_wdata = wd;
    bus.cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    acc_cyc = cyc;
  endtask

  task automatic run_cmd(input logic rw, input logic [6:0] dev,
                         input logic [7:0] rg, input logic [7:0] wd,
                         input string tag, output int lat);
    int d0;
    log_q.delete();
    issue(rw, dev, rg, wd);
    bus.cmd_valid = 1'b0;
    d0 = done_cnt;
    chk({tag, "_busy"}, bus.busy, 1'b1);
    chk({tag, "_ackclr"}, bus.ack_err, 1'b0);
    wait_done(tag, lat);
    @(negedge clk);
    chk({tag, "_npulse"}, done_cnt - d0, 1);
    chk({tag, "_done_lo"}, bus.done, 1'b0);
  endtask

  int lat;
  int d0;

  initial begin
    rst_n = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.cmd_rw = I2C_RW_WRITE;
    bus.cmd_dev = '0;
    bus.cmd_reg = '0;
    bus.cmd_wdata = '0;
    str_en = 1'b0;
    rd_byte = 8'h3C;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_ready", bus.cmd_ready, 1'b1);
    chk("rst_scl_oe", bus.scl_oe, 1'b0);
    chk("rst_sda_oe", bus.sda_oe, 1'b0);
    chk("rst_done", bus.done, 1'b0);
    chk("rst_ack_err", bus.ack_err, 1'b0);
    chk("rst_rdata", bus.rdata, 8'h00);
    chk("rst_scl_o", bus.scl_o, 1'b0);
    chk("rst_sda_o", bus.sda_o, 1'b0);

    // register write, acked throughout
    run_cmd(I2C_RW_WRITE, 7'h70, 8'h12, 8'hA5, "wr", lat);
    chk("wr_lat", lat, TW);
    chk("wr_ack_err", bus.ack_err, 1'b0);
    exp_q = '{EV_S, 'hE0, ACK, 'h12, ACK, 'hA5, ACK, EV_P};
    check_log("wr");

    // register read with repeated start
    run_cmd(I2C_RW_READ, 7'h70, 8'h34, 8'h00, "rd", lat);
    chk("rd_lat", lat, TR);
    chk("rd_rdata", bus.rdata, 8'h3C);
    chk("rd_ack_err", bus.ack_err, 1'b0);
    exp_q = '{EV_S, 'hE0, ACK, 'h34, ACK,
              EV_S, 'hE1, ACK, 'h3C, NAK, EV_P};
    check_log("rd");

    // nobody answers 0x71
    run_cmd(I2C_RW_WRITE, 7'h71, 8'h12, 8'hA5, "nk", lat);
    chk("nk_lat", lat, TN);
    chk("nk_ack_err", bus.ack_err, 1'b1);
    exp_q = '{EV_S, 'hE2, NAK, EV_P};
    check_log("nk");

    // responder stretches SCL in the register byte
    str_en = 1'b1;
    run_cmd(I2C_RW_WRITE, 7'h70, 8'hC3, 8'h5A, "st", lat);
    str_en = 1'b0;
    chk("st_lat_rng", (lat > TW + 800) && (lat <= TW + 1000), 1'b1);
    chk("st_ack_err", bus.ack_err, 1'b0);
    exp_q = '{EV_S, 'hE0, ACK, 'hC3, ACK, 'h5A, ACK, EV_P};
    check_log("st");

    // cmd_valid held high, fields changed after the first accept
    log_q.delete();
    d0 = done_cnt;
    issue(I2C_RW_WRITE, 7'h70, 8'h21, 8'h96);
    chk("bb1_busy", bus.busy, 1'b1);
    bus.cmd_reg = 8'h56;
    bus.cmd_wdata = 8'h5A;
    wait_done("bb1", lat);
    chk("bb1_lat", lat, TW);
    chk("bb1_ready", bus.cmd_ready, 1'b1);
    exp_q = '{EV_S, 'hE0, ACK, 'h21, ACK, 'h96, ACK, EV_P};
    check_log("bb1");
    log_q.delete();
    @(posedge clk);
    #1;
    acc_cyc = cyc;
    bus.cmd_valid = 1'b0;
    chk("bb2_busy", bus.busy, 1'b1);
    wait_done("bb2", lat);
    chk("bb2_lat", lat, TW);
    @(negedge clk);
    chk("bb_npulse", done_cnt - d0, 2);
    exp_q = '{EV_S, 'hE0, ACK, 'h56, ACK, 'h5A, ACK, EV_P};
    check_log("bb2");

    // asynchronous reset in the middle of the address byte
    log_q.delete();
    issue(I2C_RW_WRITE, 7'h70, 8'h12, 8'hA5);
    bus.cmd_valid = 1'b0;
    repeat (1230) @(negedge clk);
    chk("rs_pre_busy", bus.busy, 1'b1);
    chk("rs_pre_scl", bus.scl_oe, 1'b1);
    chk("rs_pre_sda", bus.sda_oe, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rs_scl_oe", bus.scl_oe, 1'b0);
    chk("rs_sda_oe", bus.sda_oe, 1'b0);
    chk("rs_busy", bus.busy, 1'b0);
    chk("rs_ready", bus.cmd_ready, 1'b1);
    chk("rs_rdata", bus.rdata, 8'h00);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    run_cmd(I2C_RW_WRITE, 7'h70, 8'h77, 8'h11, "rs2", lat);
    chk("rs2_lat", lat, TW);
    chk("rs2_ack_err", bus.ack_err, 1'b0);
    exp_q = '{EV_S, 'hE0, ACK, 'h77, ACK, 'h11, ACK, EV_P};
    check_log("rs2");

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule

// File: doc/i2c_master.md
Name: i2c_master

Overview:
Single-transaction I2C controller, the initiator side of the team's i2c_slave (responder at 7-bit address 0x70).
- Performs one register write or one register read per command: device address, 8-bit register address, one data byte.
- Used for on-chip loopback and board-level test against the responder.
- Runs on the 25-50 MHz system clock; drives open-drain SCL/SDA through separate output-value and output-enable pins.

Parameters:
- QDIV, 125: system clocks per quarter SCL period. 50 MHz / (4*125) = 100 kHz. Legal range 2..65535.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous, active-low reset
- cmd_valid  in  1  request a transaction; sampled only while cmd_ready=1
- cmd_ready  out  1  equals ~busy
- cmd_rw  in  1  0 = write, 1 = read
- cmd_dev  in  7  7-bit device address
- cmd_reg  in  8  register address
- cmd_wdata  in  8  write data byte
- busy  out  1  transaction in progress
- done  out  1  one-cycle pulse after STOP completes
- ack_err  out  1  a NACK occurred in the last transaction; valid with done, held until next accept
- rdata  out  8  read byte; valid from done until next accept
- scl_o  out  1  constant 0
- scl_oe  out  1  1 = pull SCL low
- scl_i  in  1  SCL pin level, used for clock stretching
- sda_o  out  1  constant 0
- sda_oe  out  1  1 = pull SDA low
- sda_i  in  1  SDA pin level

Behaviour:
- Reset, asynchronous, at any time including mid-byte:
  - scl_oe=0, sda_oe=0 (both lines released).
  - busy=0, done=0, ack_err=0, rdata=0x00, state IDLE, quarter counter 0.
  - No STOP is generated.
- Accept: cmd_valid & cmd_ready on a rising edge latches cmd_rw, cmd_dev, cmd_reg, cmd_wdata and clears ack_err. busy=1 from the next cycle. cmd_valid while busy is ignored.
- Timebase: a 16-bit counter counts 0..QDIV-1 and produces a quarter tick on wrap. All bus actions happen on quarter ticks.
- States: IDLE, START, TXBYTE, TXACK, RSTART, RXBYTE, RXNACK, STOP.
- START (4 quarters): SDA released / SCL released; SDA low; hold; SCL low.
- Bit cell (4 quarters):
  - Q0: SCL low; set sda_oe = ~bit.
  - Q1: release SCL.
  - Q2: if scl_i=0, freeze the counter until scl_i=1 (stretching); then sample sda_i.
  - Q3: pull SCL low.
- TXBYTE: 8 bits, MSB first. TXACK: release SDA for one bit cell and sample; 0 = ACK.
- Write sequence: START, {dev,0}, ACK, reg, ACK, wdata, ACK, STOP.
- Read sequence: START, {dev,0}, ACK, reg, ACK, RSTART, {dev,1}, ACK, RXBYTE (SDA released, shift sda_i in at Q2, MSB first), RXNACK (master releases SDA = NACK), STOP.
  - RSTART: SCL low with SDA released; release SCL; SDA low; SCL low.
  - rdata updates at the end of RXBYTE.
- Any NACK in TXACK: set ack_err=1, skip remaining bytes, go directly to STOP.
- STOP (4 quarters): SDA low; release SCL; release SDA; idle quarter.
- Completion: done pulses high for exactly one cycle on the STOP final tick; busy drops the same cycle. A new command is accepted no earlier than the next cycle.
- Arbitration loss is not detected (single-master bus).
- Latency with no stretching, QDIV=125:
  - Write: 4 + 27*4 + 4 = 116 quarters = 14500 clk.
  - Read: 4 + 18*4 + 4 + 18*4 + 4 = 156 quarters.

Decomposition:
- Package i2c_pkg holds:
  - the state enum;
  - I2C_RW_WRITE/I2C_RW_READ;
  - default device address 7'h70;
  - quarter-phase constants Q0..Q3.
- One sub-module, i2c_qtick: quarter-period counter with a stretch-hold input and tick output.

Test Plan:
- Write dev=0x70 reg=0x12 wdata=0xA5, responder model ACKs all bytes -> bus bytes E0,12,A5 with START/STOP framing, done after 14500 clk, ack_err=0.
- Read dev=0x70 reg=0x34, model returns 0x3C -> bytes E0,34, repeated start, E1, master NACK on data, STOP; rdata=0x3C at done, ack_err=0.
- Write dev=0x71, no responder ACK -> ack_err=1, STOP immediately after first ACK slot, no reg or data byte on bus, single done pulse.
- Model holds SCL low 1000 clk during the second byte's bit 3 -> SDA sample delayed until SCL high, transfer completes with data intact, latency +~1000 clk.
- cmd_valid held high through a transaction with changed fields -> second command starts only after done, with fields latched at its own accept.
- rst_n low mid-TXBYTE -> scl_oe=sda_oe=0 and busy=0 immediately (asynchronous); after release, a fresh write completes normally.
